rptr_empty: RTL and testbench



---
 rtl/rptr_empty_pkg.sv | 25 ++
 rtl/rptr_empty_gray2bin.sv | 14 +
 rtl/rptr_empty.sv | 60 ++++++
 tb/tb_rptr_empty.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/rptr_empty_pkg.sv
// rtl/rptr_empty_pkg.sv - shared async FIFO pointer helpers and reset constants
package rptr_empty_pkg;

  localparam int FIFO_ASIZE_DEFAULT = 4;
  // Widest pointer supported (ASIZE up to 12 plus the lap bit)
  localparam int GRAY_MAX_W = 13;

  localparam logic RST_EMPTY        = 1'b1;
  localparam logic RST_ALMOST_EMPTY = 1'b1;
  localparam logic RST_UNDERFLOW    = 1'b0;

  function automatic logic [GRAY_MAX_W-1:0] gray_encode(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray_decode(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/rptr_empty_gray2bin.sv
// rtl/rptr_empty_gray2bin.sv - combinational Gray-to-binary converter of width N
module rptr_empty_gray2bin #(
  parameter int N = 5
) (
  input  logic [N-1:0] gray,
  output logic [N-1:0] bin
);

  // Each binary bit is the XOR of its Gray bit and every bit above it
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign bin[i] = ^(gray >> i);
  end

endmodule

// File: rtl/rptr_empty.sv
// rtl/rptr_empty.sv - read-domain pointer, empty/almost-empty, occupancy and underflow
module rptr_empty
  import rptr_empty_pkg::*;
#(
  parameter int ASIZE     = FIFO_ASIZE_DEFAULT,
  parameter int AE_THRESH = 2
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rinc,
  input  logic [ASIZE:0]   rs_wptr,
  output logic [ASIZE-1:0] raddr,
  output logic [ASIZE:0]   rptr,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   rcount,
  output logic             runderflow
);

  localparam int PW = ASIZE + 1;
  localparam logic [ASIZE:0] AE_LIMIT = PW'(AE_THRESH);

  logic [ASIZE:0] rbin;
  logic [ASIZE:0] rbin_next;
  logic [ASIZE:0] rgray_next;
  logic [ASIZE:0] wbin_s;
  logic [ASIZE:0] occ_next;
  logic           rd_ok;

  rptr_empty_gray2bin #(.N(PW)) u_wptr_g2b (
    .gray (rs_wptr),
    .bin  (wbin_s)
  );

  assign rd_ok      = rinc & ~rempty;
  assign rbin_next  = rbin + PW'(rd_ok);
  assign rgray_next = PW'(gray_encode(GRAY_MAX_W'(rbin_next)));
  // Flags look at the post-read pointer so the last read shows empty on the next edge
  assign occ_next   = wbin_s - rbin_next;
  assign raddr      = rbin[ASIZE-1:0];

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= RST_EMPTY;
      ralmost_empty <= RST_ALMOST_EMPTY;
      rcount        <= '0;
      runderflow    <= RST_UNDERFLOW;
    end else begin
      rbin          <= rbin_next;
      rptr          <= rgray_next;
      rempty        <= (rgray_next == rs_wptr);
      ralmost_empty <= (occ_next <= AE_LIMIT);
      rcount        <= occ_next;
      runderflow    <= runderflow | (rinc & rempty);
    end
  end

endmodule

// File: tb/tb_rptr_empty.sv
// tb/tb_rptr_empty.sv - scoreboard bench for rptr_empty (ASIZE=4, AE_THRESH=2)
module tb_rptr_empty;

  typedef struct packed {
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       ralmost_empty;
    logic [4:0] rcount;
    logic       runderflow;
  } exp_t;

  logic       rclk = 1'b0;
  logic       rrst = 1'b1;
  logic       rinc = 1'b0;
  logic [4:0] rs_wptr = 5'd0;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       rempty;
  logic       ralmost_empty;
  logic [4:0] rcount;
  logic       runderflow;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vec_id  = 0;

  rptr_empty #(.ASIZE(4), .AE_THRESH(2)) dut (
    .rclk          (rclk),
    .rrst          (rrst),
    .rinc          (rinc),
    .rs_wptr       (rs_wptr),
    .raddr         (raddr),
    .rptr          (rptr),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rcount        (rcount),
    .runderflow    (runderflow)
  );

  always #5 rclk = ~rclk;

  function automatic logic [4:0] g(input int k);
    logic [4:0] b;
    b = 5'(k);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int id, input logic [4:0] act, input logic [4:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %b expected %b", id, name, act, req);
    end
  endtask

  // Monitor: registered outputs are compared one edge after each issued vector
  always @(negedge rclk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("raddr",         vec_id, {1'b0, raddr},         {1'b0, e.raddr});
      chk("rptr",          vec_id, rptr,                  e.rptr);
      chk("rempty",        vec_id, {4'b0, rempty},        {4'b0, e.rempty});
      chk("ralmost_empty", vec_id, {4'b0, ralmost_empty}, {4'b0, e.ralmost_empty});
      chk("rcount",        vec_id, rcount,                e.rcount);
      chk("runderflow",    vec_id, {4'b0, runderflow},    {4'b0, e.runderflow});
      vec_id++;
    end
  end

  task automatic step(input logic rst, input logic inc, input logic [4:0] wp,
                      input int ea, input logic [4:0] ep, input logic ee,
                      input logic eae, input int ec, input logic eu);
    exp_t e;
    @(negedge rclk);
    rrst    = rst;
    rinc    = inc;
    rs_wptr = wp;
    @(posedge rclk);
    #1;
    e.raddr         = 4'(ea);
    e.rptr          = ep;
    e.rempty        = ee;
    e.ralmost_empty = eae;
    e.rcount        = 5'(ec);
    e.runderflow    = eu;
    exp_q.push_back(e);
  endtask

  initial begin
    // Reset held two cycles with rinc asserted
    step(1, 1, 5'b00000, 0, 5'b00000, 1, 1, 0, 0);
    step(1, 1, 5'b00000, 0, 5'b00000, 1, 1, 0, 0);
    // Writer publishes 5 words
    step(0, 0, 5'b00111, 0, 5'b00000, 0, 0, 5, 0);
    step(0, 1, 5'b00111, 1, 5'b00001, 0, 0, 4, 0);
    step(0, 1, 5'b00111, 2, 5'b00011, 0, 0, 3, 0);
    step(0, 1, 5'b00111, 3, 5'b00010, 0, 1, 2, 0);
    step(0, 1, 5'b00111, 4, 5'b00110, 0, 1, 1, 0);
    step(0, 1, 5'b00111, 5, 5'b00111, 1, 1, 0, 0);
    // Reads while empty: pointer frozen, underflow sticky
    step(0, 1, 5'b00111, 5, 5'b00111, 1, 1, 0, 1);
    step(0, 1, 5'b00111, 5, 5'b00111, 1, 1, 0, 1);
    step(0, 1, 5'b00111, 5, 5'b00111, 1, 1, 0, 1);
    step(0, 0, 5'b00111, 5, 5'b00111, 1, 1, 0, 1);
    // Full FIFO then drain across the lap boundary
    step(1, 0, 5'b11000, 0, 5'b00000, 1, 1, 0, 0);
    step(0, 0, 5'b11000, 0, 5'b00000, 0, 0, 16, 0);
    for (int k = 1; k <= 16; k++)
      step(0, 1, 5'b11000, k % 16, g(k), k == 16, (16 - k) <= 2, 16 - k, 0);
    // Second lap: writer and reader alternate one word at a time
    for (int j = 17; j <= 32; j++) begin
      step(0, 0, g(j), (j - 1) % 16, g(j - 1), 0, 1, 1, 0);
      step(0, 1, g(j), j % 16, g(j), 1, 1, 0, 0);
    end
    // Read and writer advance in the same cycle
    step(0, 0, 5'b00001, 0, 5'b00000, 0, 1, 1, 0);
    step(0, 1, 5'b00011, 1, 5'b00001, 0, 1, 1, 0);
    // Build occupancy 7, then reset mid-operation
    step(0, 0, 5'b01101, 1, 5'b00001, 0, 0, 8, 0);
    step(0, 1, 5'b01101, 2, 5'b00011, 0, 0, 7, 0);
    step(0, 1, 5'b01101, 3, 5'b00010, 0, 0, 6, 0);
    step(1, 1, 5'b01101, 0, 5'b00000, 1, 1, 0, 0);
    step(0, 0, 5'b01101, 0, 5'b00000, 0, 0, 9, 0);
    step(0, 1, 5'b01101, 1, 5'b00001, 0, 0, 8, 0);
    step(0, 1, 5'b01101, 2, 5'b00011, 0, 0, 7, 0);

    rinc = 1'b0;
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge rclk);
    @(negedge rclk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
